// File: rtl/ioctl_ram_arbiter_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : ioctl_ram_arbiter_if                                          |
// | Brief    : Download, CPU and RAM bus signals shared with the arbiter.    |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
interface ioctl_ram_arbiter_if #(
    parameter int AW = 24
);
    logic          ioctl_download;
    logic          ioctl_wr;
    logic [AW:0]   ioctl_addr;
    logic [15:0]   ioctl_dout;

    logic          cpu_req;
    logic          cpu_we;
    logic [AW:0]   cpu_addr;
    logic [7:0]    cpu_din;
    logic [7:0]    cpu_dout;
    logic          cpu_ack;

    logic          ram_req;
    logic          ram_we;
    logic [AW-1:0] ram_addr;
    logic [15:0]   ram_din;
    logic [1:0]    ram_be;
    logic [15:0]   ram_dout;
    logic          ram_ack;

    // Arbiter side.
    modport master (
        input  ioctl_download, ioctl_wr, ioctl_addr, ioctl_dout,
        input  cpu_req, cpu_we, cpu_addr, cpu_din,
        output cpu_dout, cpu_ack,
        output ram_req, ram_we, ram_addr, ram_din, ram_be,
        input  ram_dout, ram_ack
    );

    // Environment side: data_io, CPU core and RAM controller.
    modport slave (
        output ioctl_download, ioctl_wr, ioctl_addr, ioctl_dout,
        output cpu_req, cpu_we, cpu_addr, cpu_din,
        input  cpu_dout, cpu_ack,
        input  ram_req, ram_we, ram_addr, ram_din, ram_be,
        output ram_dout, ram_ack
    );
endinterface
`default_nettype wire

// File: rtl/ioctl_ram_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : ioctl_ram_arbiter                                             |
// | Brief    : Shares one 16-bit RAM port between CPU byte accesses and a    |
// |            FIFO-buffered ioctl download stream. Optional download        |
// |            checksum output enabled by IOCTL_ARB_CHECKSUM_EN.             |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module ioctl_ram_arbiter #(
    parameter int AW         = 24,
    parameter int FIFO_DEPTH = 4
) (
    input  wire                 clk_sys,
    input  wire                 reset_n,
    ioctl_ram_arbiter_if.master bus,
    output logic                fifo_overflow,
    output logic                dl_done
`ifdef IOCTL_ARB_CHECKSUM_EN
    ,
    output logic [15:0]         dl_checksum
`endif
);

    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [PW:0]   c_cnt_full = (PW+1)'(FIFO_DEPTH);
    localparam logic [PW:0]   c_cnt_high = (PW+1)'(FIFO_DEPTH - 1);
    localparam logic [PW-1:0] c_ptr_one  = PW'(1);
    localparam logic [PW:0]   c_cnt_one  = (PW+1)'(1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CPU_ACC = 2'd1,
        ST_DL_ACC  = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic          ram_req_q, ram_req_d;
    logic          ram_we_q, ram_we_d;
    logic [AW-1:0] ram_addr_q, ram_addr_d;
    logic [15:0]   ram_din_q, ram_din_d;
    logic [1:0]    ram_be_q, ram_be_d;
    logic          cpu_ack_q, cpu_ack_d;
    logic [7:0]    cpu_dout_q, cpu_dout_d;
    logic          last_dl_q, last_dl_d;
    logic          cpu_block_q, cpu_block_d;

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW:0]   count_q, count_d;
    logic [AW-1:0] fifo_addr_mem [FIFO_DEPTH];
    logic [15:0]   fifo_data_mem [FIFO_DEPTH];

    logic          download_q, download_d;
    logic          pend_done_q, pend_done_d;
    logic          overflow_q, overflow_d;

    logic          w_fifo_empty;
    logic          w_fifo_full;
    logic          w_push;
    logic          w_pop;
    logic          w_drop;
    logic          w_dl_rise;
    logic          w_dl_fall;
    logic          w_dl_done;
    logic          w_cpu_pend;
    logic          w_cpu_win;
    logic [AW-1:0] w_head_addr;
    logic [15:0]   w_head_data;
    logic          w_unused;

    assign w_unused = bus.ioctl_addr[0];

    // ------------------------------------------------------------------
    // Download FIFO
    // ------------------------------------------------------------------
    assign w_fifo_empty = (count_q == '0);
    assign w_fifo_full  = (count_q == c_cnt_full);
    assign w_pop        = (state_q == ST_DL_ACC) && bus.ram_ack;
    // A pop in the same cycle frees the slot, so a push at full still lands.
    assign w_push       = bus.ioctl_wr && (!w_fifo_full || w_pop);
    assign w_drop       = bus.ioctl_wr && w_fifo_full && !w_pop;
    assign w_head_addr  = fifo_addr_mem[rd_ptr_q];
    assign w_head_data  = fifo_data_mem[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (w_push) begin
            wr_ptr_d = wr_ptr_q + c_ptr_one;
        end
        if (w_pop) begin
            rd_ptr_d = rd_ptr_q + c_ptr_one;
        end
        if (w_push && !w_pop) begin
            count_d = count_q + c_cnt_one;
        end else if (w_pop && !w_push) begin
            count_d = count_q - c_cnt_one;
        end
    end

    always_ff @(posedge clk_sys) begin
        if (w_push) begin
            fifo_addr_mem[wr_ptr_q] <= bus.ioctl_addr[AW:1];
            fifo_data_mem[wr_ptr_q] <= bus.ioctl_dout;
        end
    end

    // ------------------------------------------------------------------
    // Arbitration FSM
    // ------------------------------------------------------------------
    assign w_cpu_pend = bus.cpu_req && !cpu_block_q;
    assign w_cpu_win  = w_cpu_pend &&
                        (w_fifo_empty || (last_dl_q && (count_q < c_cnt_high)));

    always_comb begin
        state_d     = state_q;
        ram_req_d   = ram_req_q;
        ram_we_d    = ram_we_q;
        ram_addr_d  = ram_addr_q;
        ram_din_d   = ram_din_q;
        ram_be_d    = ram_be_q;
        cpu_ack_d   = 1'b0;
        cpu_dout_d  = cpu_dout_q;
        last_dl_d   = last_dl_q;
        cpu_block_d = cpu_block_q;

        // The request being acked is still held high during cpu_ack.
        if (cpu_ack_q || !bus.cpu_req) begin
            cpu_block_d = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                if (w_cpu_win) begin
                    state_d    = ST_CPU_ACC;
                    ram_req_d  = 1'b1;
                    ram_we_d   = bus.cpu_we;
                    ram_addr_d = bus.cpu_addr[AW:1];
                    ram_din_d  = {bus.cpu_din, bus.cpu_din};
                    if (bus.cpu_we) begin
                        ram_be_d = bus.cpu_addr[0] ? 2'b10 : 2'b01;
                    end else begin
                        ram_be_d = 2'b11;
                    end
                end else if (!w_fifo_empty) begin
                    state_d    = ST_DL_ACC;
                    ram_req_d  = 1'b1;
                    ram_we_d   = 1'b1;
                    ram_addr_d = w_head_addr;
                    ram_din_d  = w_head_data;
                    ram_be_d   = 2'b11;
                end
            end
            ST_CPU_ACC: begin
                if (bus.ram_ack) begin
                    state_d     = ST_IDLE;
                    ram_req_d   = 1'b0;
                    last_dl_d   = 1'b0;
                    cpu_ack_d   = 1'b1;
                    cpu_block_d = 1'b1;
                    if (!ram_we_q) begin
                        cpu_dout_d = bus.cpu_addr[0] ? bus.ram_dout[15:8]
                                                     : bus.ram_dout[7:0];
                    end
                end
            end
            ST_DL_ACC: begin
                if (bus.ram_ack) begin
                    state_d   = ST_IDLE;
                    ram_req_d = 1'b0;
                    last_dl_d = 1'b1;
                end
            end
            default: begin
                state_d   = ST_IDLE;
                ram_req_d = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Download completion and overflow tracking
    // ------------------------------------------------------------------
    assign w_dl_rise = bus.ioctl_download && !download_q;
    assign w_dl_fall = !bus.ioctl_download && download_q;
    assign w_dl_done = pend_done_q && w_fifo_empty && (state_q != ST_DL_ACC);

    always_comb begin
        download_d  = bus.ioctl_download;
        pend_done_d = pend_done_q;
        overflow_d  = overflow_q;
        if (w_dl_done) begin
            pend_done_d = 1'b0;
        end
        if (w_dl_fall) begin
            pend_done_d = 1'b1;
        end
        if (w_dl_rise) begin
            pend_done_d = 1'b0;
            overflow_d  = 1'b0;
        end
        if (w_drop) begin
            overflow_d = 1'b1;
        end
    end

`ifdef IOCTL_ARB_CHECKSUM_EN
    logic [15:0] checksum_q, checksum_d;

    always_comb begin
        checksum_d = checksum_q;
        if (w_dl_rise) begin
            checksum_d = 16'h0000;
        end else if (w_pop) begin
            checksum_d = checksum_q + w_head_data;
        end
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            checksum_q <= 16'h0000;
        end else begin
            checksum_q <= checksum_d;
        end
    end

    assign dl_checksum = checksum_q;
`endif

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            ram_req_q   <= 1'b0;
            ram_we_q    <= 1'b0;
            ram_addr_q  <= '0;
            ram_din_q   <= 16'h0000;
            ram_be_q    <= 2'b00;
            cpu_ack_q   <= 1'b0;
            cpu_dout_q  <= 8'h00;
            last_dl_q   <= 1'b0;
            cpu_block_q <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            download_q  <= 1'b0;
            pend_done_q <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            ram_req_q   <= ram_req_d;
            ram_we_q    <= ram_we_d;
            ram_addr_q  <= ram_addr_d;
            ram_din_q   <= ram_din_d;
            ram_be_q    <= ram_be_d;
            cpu_ack_q   <= cpu_ack_d;
            cpu_dout_q  <= cpu_dout_d;
            last_dl_q   <= last_dl_d;
            cpu_block_q <= cpu_block_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            download_q  <= download_d;
            pend_done_q <= pend_done_d;
            overflow_q  <= overflow_d;
        end
    end

    assign bus.ram_req   = ram_req_q;
    assign bus.ram_we    = ram_we_q;
    assign bus.ram_addr  = ram_addr_q;
    assign bus.ram_din   = ram_din_q;
    assign bus.ram_be    = ram_be_q;
    assign bus.cpu_ack   = cpu_ack_q;
    assign bus.cpu_dout  = cpu_dout_q;
    assign fifo_overflow = overflow_q;
    assign dl_done       = w_dl_done;

endmodule
`default_nettype wire

// File: tb/tb_ioctl_ram_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_ioctl_ram_arbiter                                          |
// | Brief    : Scoreboard bench for ioctl_ram_arbiter (directed vectors).    |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module tb_ioctl_ram_arbiter;
    localparam int AW = 24;

    typedef struct {
        logic          we;
        logic [AW-1:0] addr;
        logic [15:0]   din;
        logic          chk_din;
        logic [1:0]    be;
        logic          is_cpu;
        logic          chk_rd;
        logic [7:0]    cpu_rd;
    } ram_exp_t;

    logic clk_sys = 1'b0;
    logic reset_n = 1'b0;
    logic fifo_overflow;
    logic dl_done;
`ifdef IOCTL_ARB_CHECKSUM_EN
    logic [15:0] dl_checksum;
`endif

    always #5 clk_sys = ~clk_sys;

    ioctl_ram_arbiter_if #(.AW(AW)) bus ();

    ioctl_ram_arbiter #(.AW(AW), .FIFO_DEPTH(4)) dut (
        .clk_sys       (clk_sys),
        .reset_n       (reset_n),
        .bus           (bus),
        .fifo_overflow (fifo_overflow),
        .dl_done       (dl_done)
`ifdef IOCTL_ARB_CHECKSUM_EN
        ,
        .dl_checksum   (dl_checksum)
`endif
    );

    ram_exp_t    exp_q[$];
    int          checks      = 0;
    int          errors      = 0;
    int          dl_done_cnt = 0;
    bit          hold        = 1'b0;
    int          ack_lat     = 3;
    logic [15:0] rd_data     = 16'h0000;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic ram_exp_t dl_e(input logic [24:0] a, input logic [15:0] d);
        ram_exp_t e;
        e.we = 1'b1; e.addr = a[24:1]; e.din = d; e.chk_din = 1'b1; e.be = 2'b11;
        e.is_cpu = 1'b0; e.chk_rd = 1'b0; e.cpu_rd = 8'h00;
        return e;
    endfunction

    function automatic ram_exp_t cpu_e(input logic we, input logic [24:0] a,
                                       input logic [7:0] d, input logic [7:0] rd);
        ram_exp_t e;
        e.we = we; e.addr = a[24:1]; e.din = {d, d}; e.chk_din = we;
        e.be = we ? (a[0] ? 2'b10 : 2'b01) : 2'b11;
        e.is_cpu = 1'b1; e.chk_rd = !we; e.cpu_rd = rd;
        return e;
    endfunction

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    // RAM controller model: acks ack_lat cycles into a request unless held.
    initial begin : responder
        int wait_cnt;
        wait_cnt = 0;
        bus.ram_ack  = 1'b0;
        bus.ram_dout = 16'h0000;
        forever begin
            tick();
            if (hold) begin
                wait_cnt = 0;
            end else begin
                bus.ram_ack = 1'b0;
                if (bus.ram_req && reset_n) begin
                    wait_cnt++;
                    if (wait_cnt >= ack_lat) begin
                        bus.ram_ack  = 1'b1;
                        bus.ram_dout = rd_data;
                        wait_cnt     = 0;
                    end
                end else begin
                    wait_cnt = 0;
                end
            end
        end
    end

    // Monitor: pops the scoreboard on every completed RAM access.
    initial begin : monitor
        bit       ack_due;
        bit       rd_due;
        logic [7:0] rd_exp;
        ram_exp_t e;
        ack_due = 1'b0;
        rd_due  = 1'b0;
        rd_exp  = 8'h00;
        forever begin
            @(negedge clk_sys);
            if (!reset_n) begin
                ack_due = 1'b0;
                rd_due  = 1'b0;
            end else begin
                if (bus.cpu_ack || ack_due) chk("cpu_ack_timing", 32'(bus.cpu_ack), 32'(ack_due));
                if (bus.cpu_ack && rd_due) chk("cpu_dout", 32'(bus.cpu_dout), 32'(rd_exp));
                ack_due = 1'b0;
                rd_due  = 1'b0;
                if (dl_done) begin
                    dl_done_cnt++;
                    chk("dl_done_drained", 32'(exp_q.size() == 0), 32'd1);
                end
                if (bus.ram_req && bus.ram_ack) begin
                    if (exp_q.size() == 0) begin
                        chk("ram_unexpected_access", 32'(bus.ram_addr), 32'hFFFF_FFFF);
                    end else begin
                        e = exp_q.pop_front();
                        chk("ram_we",   32'(bus.ram_we),   32'(e.we));
                        chk("ram_addr", 32'(bus.ram_addr), 32'(e.addr));
                        chk("ram_be",   32'(bus.ram_be),   32'(e.be));
                        if (e.chk_din) chk("ram_din", 32'(bus.ram_din), 32'(e.din));
                        ack_due = e.is_cpu;
                        rd_due  = e.chk_rd;
                        rd_exp  = e.cpu_rd;
                    end
                end
            end
        end
    end

    task automatic push_dl(input logic [24:0] a, input logic [15:0] d);
        bus.ioctl_wr   = 1'b1;
        bus.ioctl_addr = a;
        bus.ioctl_dout = d;
        tick();
        bus.ioctl_wr   = 1'b0;
    endtask

    task automatic wait_req(input int budget);
        int n;
        n = 0;
        while (!bus.ram_req && n < budget) begin
            tick();
            n++;
        end
        if (!bus.ram_req) chk("ram_req_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_cpu_acks(input int n, input int budget);
        int seen;
        seen = 0;
        for (int i = 0; i < budget && seen < n; i++) begin
            tick();
            if (bus.cpu_ack) seen++;
        end
        if (seen != n) chk("cpu_ack_timeout", 32'(seen), 32'(n));
    endtask

    task automatic wait_drain(input int budget);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || bus.ram_req) && n < budget) begin
            tick();
            n++;
        end
        if (exp_q.size() != 0 || bus.ram_req) chk("drain_timeout", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic cpu_access(input logic we, input logic [24:0] a,
                              input logic [7:0] d, input logic [7:0] rd);
        exp_q.push_back(cpu_e(we, a, d, rd));
        bus.cpu_we   = we;
        bus.cpu_addr = a;
        bus.cpu_din  = d;
        bus.cpu_req  = 1'b1;
        wait_cpu_acks(1, 40);
        bus.cpu_req  = 1'b0;
        tick();
    endtask

    initial begin : watchdog
        #400000;
        errors++;
        $display("FAIL watchdog actual=timeout required=finish");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin : stimulus
        bit seen_req;
        bus.ioctl_download = 1'b0;
        bus.ioctl_wr       = 1'b0;
        bus.ioctl_addr     = '0;
        bus.ioctl_dout     = 16'h0000;
        bus.cpu_req        = 1'b0;
        bus.cpu_we         = 1'b0;
        bus.cpu_addr       = '0;
        bus.cpu_din        = 8'h00;

        // Reset state
        tick();
        tick();
        chk("rst_ram_req",  32'(bus.ram_req),  32'd0);
        chk("rst_ram_we",   32'(bus.ram_we),   32'd0);
        chk("rst_ram_addr", 32'(bus.ram_addr), 32'd0);
        chk("rst_ram_din",  32'(bus.ram_din),  32'd0);
        chk("rst_ram_be",   32'(bus.ram_be),   32'd0);
        chk("rst_cpu_ack",  32'(bus.cpu_ack),  32'd0);
        chk("rst_cpu_dout", 32'(bus.cpu_dout), 32'd0);
        chk("rst_dl_done",  32'(dl_done),      32'd0);
        chk("rst_overflow", 32'(fifo_overflow), 32'd0);
        reset_n = 1'b1;
        tick();

        // Reset during an in-flight download write
        bus.ioctl_download = 1'b1;
        hold = 1'b1;
        tick();
        push_dl(25'h000010, 16'hAAAA);
        wait_req(10);
        #3;
        reset_n = 1'b0;
        #1;
        chk("midrst_ram_req", 32'(bus.ram_req), 32'd0);
        chk("midrst_ram_we",  32'(bus.ram_we),  32'd0);
        bus.ioctl_download = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;
        hold = 1'b0;
        seen_req = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (bus.ram_req) seen_req = 1'b1;
        end
        chk("midrst_fifo_empty", 32'(seen_req), 32'd0);
        chk("midrst_dl_done",    32'(dl_done_cnt), 32'd0);
        chk("midrst_overflow",   32'(fifo_overflow), 32'd0);

        // Three-word download followed by completion
        bus.ioctl_download = 1'b1;
        tick();
        exp_q.push_back(dl_e(25'h000000, 16'h1234));
        exp_q.push_back(dl_e(25'h000002, 16'h5678));
        exp_q.push_back(dl_e(25'h000004, 16'h9ABC));
        push_dl(25'h000000, 16'h1234);
        push_dl(25'h000002, 16'h5678);
        push_dl(25'h000004, 16'h9ABC);
        bus.ioctl_download = 1'b0;
        wait_drain(100);
        for (int i = 0; i < 4; i++) tick();
        chk("dl_done_count_1", 32'(dl_done_cnt), 32'd1);
`ifdef IOCTL_ARB_CHECKSUM_EN
        chk("dl_checksum", 32'(dl_checksum), 32'h0368);
`endif

        // CPU byte write and reads
        cpu_access(1'b1, 25'h000003, 8'h5A, 8'h00);
        rd_data = 16'hBEEF;
        cpu_access(1'b0, 25'h000002, 8'h00, 8'hEF);
        cpu_access(1'b0, 25'h000003, 8'h00, 8'hBE);
        cpu_access(1'b1, 25'h000010, 8'hC3, 8'h00);
        wait_drain(50);

        // Alternating grants with a continuous CPU request
        hold = 1'b1;
        exp_q.push_back(dl_e(25'h000100, 16'h1111));
        push_dl(25'h000100, 16'h1111);
        wait_req(10);
        bus.cpu_we   = 1'b1;
        bus.cpu_addr = 25'h000041;
        bus.cpu_din  = 8'h77;
        bus.cpu_req  = 1'b1;
        push_dl(25'h000102, 16'h2222);
        exp_q.push_back(cpu_e(1'b1, 25'h000041, 8'h77, 8'h00));
        exp_q.push_back(dl_e(25'h000102, 16'h2222));
        exp_q.push_back(cpu_e(1'b1, 25'h000041, 8'h77, 8'h00));
        hold = 1'b0;
        wait_cpu_acks(2, 100);
        bus.cpu_req = 1'b0;
        wait_drain(100);

        // FIFO at DEPTH-1 forces the download even after a DL grant
        hold = 1'b1;
        exp_q.push_back(dl_e(25'h000200, 16'hA1A1));
        push_dl(25'h000200, 16'hA1A1);
        wait_req(10);
        bus.cpu_we   = 1'b1;
        bus.cpu_addr = 25'h000081;
        bus.cpu_din  = 8'h33;
        bus.cpu_req  = 1'b1;
        push_dl(25'h000202, 16'hB2B2);
        push_dl(25'h000204, 16'hC3C3);
        push_dl(25'h000206, 16'hD4D4);
        exp_q.push_back(dl_e(25'h000202, 16'hB2B2));
        exp_q.push_back(cpu_e(1'b1, 25'h000081, 8'h33, 8'h00));
        exp_q.push_back(dl_e(25'h000204, 16'hC3C3));
        exp_q.push_back(cpu_e(1'b1, 25'h000081, 8'h33, 8'h00));
        exp_q.push_back(dl_e(25'h000206, 16'hD4D4));
        chk("full_no_overflow", 32'(fifo_overflow), 32'd0);
        hold = 1'b0;
        wait_cpu_acks(2, 150);
        bus.cpu_req = 1'b0;
        wait_drain(100);

        // Overflow, clear on download rise, push+pop at full
        bus.ioctl_download = 1'b1;
        hold = 1'b1;
        tick();
        for (int i = 0; i < 5; i++) begin
            if (i < 4) exp_q.push_back(dl_e(25'(32'h300 + 2*i), 16'(32'h5000 + i)));
            push_dl(25'(32'h300 + 2*i), 16'(32'h5000 + i));
        end
        tick();
        chk("overflow_set", 32'(fifo_overflow), 32'd1);
        bus.ioctl_download = 1'b0;
        tick();
        bus.ioctl_download = 1'b1;
        tick();
        chk("overflow_cleared", 32'(fifo_overflow), 32'd0);
        exp_q.push_back(dl_e(25'h000310, 16'h6666));
        bus.ram_ack  = 1'b1;
        bus.ram_dout = 16'h0000;
        push_dl(25'h000310, 16'h6666);
        bus.ram_ack  = 1'b0;
        tick();
        chk("pushpop_full_no_overflow", 32'(fifo_overflow), 32'd0);
        hold = 1'b0;
        wait_drain(200);
        bus.ioctl_download = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        chk("dl_done_count_2", 32'(dl_done_cnt), 32'd2);
        chk("final_overflow",  32'(fifo_overflow), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
